// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, jump, relative branch, call/return
// with a circular return-address stack and sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned STEP = 1,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             stall,
  input  logic             load,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [PW-1:0] PMAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic             r_unf;

  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_top;
  logic [PW-1:0]    w_wp_inc;
  logic [PW-1:0]    w_wp_dec;
  logic             w_empty;
  logic             w_full;
  logic             w_do_ret;
  logic             w_do_call;
  logic             w_do_load;
  logic             w_do_br;

  assign w_seq    = r_pc + STEP_W;
  assign w_wp_inc = (r_wp == PMAX) ? '0 : r_wp + 1'b1;
  assign w_wp_dec = (r_wp == '0) ? PMAX : r_wp - 1'b1;
  assign w_top    = r_ras[w_wp_dec];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CMAX);

  // Fixed priority flattened to one-hot: ret > call > load > branch.
  assign w_do_ret  = ret;
  assign w_do_call = call & ~ret;
  assign w_do_load = load & ~ret & ~call;
  assign w_do_br   = branch & ~ret & ~call & ~load;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pc  <= RESET_VECTOR;
      r_wp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!stall) begin
      if (flag_clr) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      unique case (1'b1)
        w_do_ret: begin
          if (w_empty) begin
            r_pc  <= w_seq;
            r_unf <= 1'b1;
          end else begin
            r_pc  <= w_top;
            r_wp  <= w_wp_dec;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        w_do_call: begin
          r_pc <= target;
          r_wp <= w_wp_inc;
          if (w_full) r_ovf <= 1'b1;
          else        r_cnt <= r_cnt + 1'b1;
        end
        w_do_load: r_pc <= target;
        w_do_br:   r_pc <= r_pc + offset;
        default:   r_pc <= w_seq;
      endcase
    end
  end

  // When full, r_wp already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clock) begin
    if (clear_n && !stall && w_do_call) r_ras[r_wp] <= w_seq;
  end

  assign pc            = r_pc;
  assign pc_seq        = w_seq;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule
